sram_march_bist: RTL

- Parametrised March C- self-test engine for the single-port IHP SRAM macros; drives the macro's BIST port (clock enable, R/W strobes, address, data, bit mask) and checks read data against expected values.
- Generalises the fixed 256x8 BIST interface to any ADDR_W/DATA_W, programmable read latency and data background.
- Adds sequencing, compare and first-fail capture logic that the bare macro does not have.
- Sits beside each macro instance; a top-level test controller pulses START and reads the status outputs.

---
 rtl/sram_bist_pkg.sv | 44 ++++
 rtl/sram_march_bist_if.sv | 30 +++
 rtl/sram_bist_cmp.sv | 67 ++++++
 rtl/sram_march_bist.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST engine.
// Elements: E0 up w0 | E1 up (r0,w1) | E2 up (r1,w0) | E3 down (r0,w1)
//           E4 down (r1,w0) | E5 up r0.  "0" is the background, "1" its inverse.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int ELEM_W = 3;

    localparam logic [ELEM_W-1:0] ELEM_FIRST = 3'd0;
    localparam logic [ELEM_W-1:0] ELEM_LAST  = 3'd5;
    // Sentinel loaded after the last op has been issued.
    localparam logic [ELEM_W-1:0] ELEM_END   = 3'd6;

    // Bit i of each table describes element i (bits 6/7 unused padding).
    localparam logic [7:0] ELEM_DESC   = 8'b0001_1000;  // E3, E4 run downwards
    localparam logic [7:0] ELEM_TWO_OP = 8'b0001_1110;  // E1..E4 have two ops
    localparam logic [7:0] OP0_WRITE   = 8'b0000_0001;  // only E0 starts with a write
    localparam logic [7:0] OP0_POL     = 8'b0001_0100;  // E2, E4 first op uses ~BG
    localparam logic [7:0] OP1_POL     = 8'b0000_1010;  // E1, E3 second op writes ~BG

    function automatic logic elem_desc(input logic [ELEM_W-1:0] e);
        return ELEM_DESC[e];
    endfunction

    function automatic logic elem_two_op(input logic [ELEM_W-1:0] e);
        return ELEM_TWO_OP[e];
    endfunction

    // The second op of a two-op element is always a write.
    function automatic logic op_is_write(input logic [ELEM_W-1:0] e, input logic op);
        return op ? 1'b1 : OP0_WRITE[e];
    endfunction

    function automatic logic op_pol(input logic [ELEM_W-1:0] e, input logic op);
        return op ? OP1_POL[e] : OP0_POL[e];
    endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// BIST port of a single-port SRAM macro. The macro's BIST clock is A_CLK.
// Strobe semantics (no valid/ready): every cycle with A_BIST_MEN=1 is exactly
// one op that the macro always accepts; WEN=1 writes A_BIST_DIN under
// A_BIST_BM, REN=1 reads, and A_BIST_DOUT is valid READ_LAT cycles after the
// read cycle. WEN and REN are never high together.
interface sram_march_bist_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              A_BIST_EN;
    logic              A_BIST_MEN;
    logic              A_BIST_WEN;
    logic              A_BIST_REN;
    logic [ADDR_W-1:0] A_BIST_ADDR;
    logic [DATA_W-1:0] A_BIST_DIN;
    logic [DATA_W-1:0] A_BIST_BM;
    logic [DATA_W-1:0] A_BIST_DOUT;

    modport master (
        output A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
        output A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
        input  A_BIST_DOUT
    );

    modport slave (
        input  A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
        input  A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
        output A_BIST_DOUT
    );
endinterface

// File: rtl/sram_bist_cmp.sv
// Read-compare path: a READ_LAT-deep pipeline of issued reads aligned with the
// macro's read latency, a comparator at the pipeline exit and first-fail capture.
module sram_bist_cmp
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ELEM_W-1:0] rd_elem,
    input  logic [DATA_W-1:0] dout,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ELEM_W-1:0] fail_elem,
    output logic [DATA_W-1:0] fail_xor
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] exp;
        logic [ADDR_W-1:0] addr;
        logic [ELEM_W-1:0] elem;
    } entry_t;

    // Stage 0 is loaded from the registered op pins, so an entry sits in the
    // last stage exactly during the cycle the macro presents its data.
    entry_t            pipe_q [READ_LAT];
    entry_t            head;
    logic [DATA_W-1:0] diff;
    logic              mismatch;

    assign head     = pipe_q[READ_LAT-1];
    assign diff     = dout ^ head.exp;
    assign mismatch = head.valid && (diff != '0);

    // Shift every cycle, including while draining and idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= '{valid: rd_valid, exp: rd_exp, addr: rd_addr, elem: rd_elem};
            for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Latch only the first mismatch; later mismatches leave the record alone.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_xor  <= '0;
        end else if (mismatch && !fail) begin
            fail      <= 1'b1;
            fail_addr <= head.addr;
            fail_elem <= head.elem;
            fail_xor  <= diff;
        end
    end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer for a single-port SRAM macro: FSM, element/op/address
// counters and registered macro strobes; read checking lives in sram_bist_cmp.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                READ_LAT = 1,   // 1..4
    parameter logic [DATA_W-1:0] BG       = {DATA_W{1'b0}}
) (
    input  logic              A_CLK,
    input  logic              A_RST,
    input  logic              START,
    sram_march_bist_if.master bist,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [ELEM_W-1:0] FAIL_ELEM,
    output logic [DATA_W-1:0] FAIL_XOR,
    output state_t            dbg_state
);

    localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [2:0]        DRAIN_LAST = 3'(READ_LAT - 1);

    state_t            state, state_n;
    // Counters point at the next op to issue while in RUN.
    logic [ELEM_W-1:0] elem, elem_n;
    logic              op, op_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [2:0]        drain_cnt, drain_n;

    logic              issue, clear_flags, busy_n;
    logic [ELEM_W-1:0] cur_elem;
    logic              cur_op;
    logic [ADDR_W-1:0] cur_addr, addr_end;
    logic              cur_desc, cur_wr, op_last;
    logic [DATA_W-1:0] cur_data;

    logic [DATA_W-1:0] rd_exp_q;
    logic [ELEM_W-1:0] rd_elem_q;

    assign dbg_state = state;

    // State and counter registers.
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state     <= ST_IDLE;
            elem      <= ELEM_FIRST;
            op        <= 1'b0;
            addr      <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            elem      <= elem_n;
            op        <= op_n;
            addr      <= addr_n;
            drain_cnt <= drain_n;
        end
    end

    // Next state, op selection and counter advance.
    always_comb begin
        state_n     = state;
        elem_n      = elem;
        op_n        = op;
        addr_n      = addr;
        drain_n     = drain_cnt;
        issue       = 1'b0;
        clear_flags = 1'b0;
        cur_elem    = elem;
        cur_op      = op;
        cur_addr    = addr;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    // Issue E0's first op on the same edge so there is no bubble.
                    state_n     = ST_RUN;
                    clear_flags = 1'b1;
                    issue       = 1'b1;
                    cur_elem    = ELEM_FIRST;
                    cur_op      = 1'b0;
                    cur_addr    = '0;
                end
            end
            ST_RUN: begin
                if (elem == ELEM_END) begin
                    state_n = ST_DRAIN;
                    drain_n = '0;
                end else begin
                    issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_n = ST_DONE;
                else                         drain_n = drain_cnt + 3'd1;
            end
            default: state_n = ST_IDLE;
        endcase

        cur_desc = elem_desc(cur_elem);
        cur_wr   = op_is_write(cur_elem, cur_op);
        cur_data = op_pol(cur_elem, cur_op) ? ~BG : BG;
        op_last  = elem_two_op(cur_elem) ? cur_op : 1'b1;
        addr_end = cur_desc ? '0 : ADDR_MAX;

        if (issue) begin
            if (!op_last) begin
                op_n   = 1'b1;
                elem_n = cur_elem;
                addr_n = cur_addr;
            end else if (cur_addr != addr_end) begin
                op_n   = 1'b0;
                elem_n = cur_elem;
                addr_n = cur_desc ? cur_addr - ADDR_ONE : cur_addr + ADDR_ONE;
            end else begin
                // Element boundary: reload the address for the next element.
                op_n = 1'b0;
                if (cur_elem == ELEM_LAST) begin
                    elem_n = ELEM_END;
                    addr_n = '0;
                end else begin
                    elem_n = cur_elem + 3'd1;
                    addr_n = elem_desc(cur_elem + 3'd1) ? ADDR_MAX : '0;
                end
            end
        end

        busy_n = (state_n == ST_RUN) || (state_n == ST_DRAIN);
    end

    // Registered macro pins, expected-data side channel and DONE flag.
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            bist.A_BIST_EN   <= 1'b0;
            bist.A_BIST_MEN  <= 1'b0;
            bist.A_BIST_WEN  <= 1'b0;
            bist.A_BIST_REN  <= 1'b0;
            bist.A_BIST_ADDR <= '0;
            bist.A_BIST_DIN  <= '0;
            bist.A_BIST_BM   <= '0;
            BUSY             <= 1'b0;
            DONE             <= 1'b0;
            rd_exp_q         <= '0;
            rd_elem_q        <= '0;
        end else begin
            bist.A_BIST_EN   <= busy_n;
            bist.A_BIST_BM   <= busy_n ? {DATA_W{1'b1}} : '0;
            BUSY             <= busy_n;
            bist.A_BIST_MEN  <= issue;
            bist.A_BIST_WEN  <= issue && cur_wr;
            bist.A_BIST_REN  <= issue && !cur_wr;
            bist.A_BIST_ADDR <= issue ? cur_addr : '0;
            bist.A_BIST_DIN  <= (issue && cur_wr) ? cur_data : '0;
            rd_exp_q         <= (issue && !cur_wr) ? cur_data : '0;
            rd_elem_q        <= issue ? cur_elem : '0;
            if (clear_flags)
                DONE <= 1'b0;
            else if (state == ST_DRAIN && state_n == ST_DONE)
                DONE <= 1'b1;
        end
    end

    sram_bist_cmp #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_cmp (
        .clk       (A_CLK),
        .rst       (A_RST),
        .clear     (clear_flags),
        .rd_valid  (bist.A_BIST_REN),
        .rd_exp    (rd_exp_q),
        .rd_addr   (bist.A_BIST_ADDR),
        .rd_elem   (rd_elem_q),
        .dout      (bist.A_BIST_DOUT),
        .fail      (FAIL),
        .fail_addr (FAIL_ADDR),
        .fail_elem (FAIL_ELEM),
        .fail_xor  (FAIL_XOR)
    );

endmodule
